// File: rtl/ifu_pkg.sv
// Shared widths, reset PC, buffered-entry layout and counter sizing for the fetch unit.
package ifu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 64'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            misalign;
  } entry_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch unit bundle: memory request/response, core instruction channel and redirect.
interface ifu_fetch_if;
  import ifu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [ILEN-1:0] rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_misalign;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc, inst_misalign,
    input  req_ready, rsp_valid, rsp_data, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc, inst_misalign,
    output req_ready, rsp_valid, rsp_data, inst_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush (flush beats push and pop in the same cycle).
// Occupancy is exposed on count_o; DEPTH must be a power of two.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic [cnt_w(DEPTH)-1:0]  count_o
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = cnt_q;

endmodule

// File: rtl/ifu_fetch.sv
// In-order instruction fetch with prefetch FIFO and redirect; request at T, inst_valid at T+2.
// IFU_MISALIGN_CHK_EN: misaligned redirect targets halt fetch and deliver one fault marker.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);

  localparam int CW = cnt_w(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            halt_q, halt_d;

  entry_t          push_ent, head_ent;
  logic            fifo_push, fifo_pop, inst_vld, req_fire;
  logic [CW-1:0]   occ, inflight;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] rsp_pc;

  // In-flight requests reserve a FIFO slot, so a response can always be accepted.
  assign credit_used   = {1'b0, occ} + {1'b0, inflight};
  assign bus.req_valid = rst && !halt_q && !bus.redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign bus.req_addr  = fetch_pc_q;
  assign req_fire      = bus.req_valid && bus.req_ready;

  assign inst_vld          = (occ != '0);
  assign fifo_pop          = inst_vld && bus.inst_ready;
  assign bus.inst_valid    = inst_vld;
  assign bus.inst          = inst_vld ? head_ent.inst : '0;
  assign bus.inst_pc       = inst_vld ? head_ent.pc   : '0;
  assign bus.inst_misalign = inst_vld && head_ent.misalign;

`ifdef IFU_MISALIGN_CHK_EN
  logic mis_pend_q, mis_pend_d;
  assign mis_pend_d = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mis_pend_q <= 1'b0;
    else      mis_pend_q <= mis_pend_d;
  end
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    halt_d     = halt_q;
    fifo_push  = 1'b0;
    push_ent   = '{pc: rsp_pc, inst: bus.rsp_data, misalign: 1'b0};
    if (bus.redirect_valid) begin
      halt_d     = 1'b0;
      // Pending drops are a subset of inflight, so everything still outstanding is dropped.
      drop_d     = inflight - CW'(bus.rsp_valid);
      fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
`ifdef IFU_MISALIGN_CHK_EN
      if (bus.redirect_pc[1:0] != 2'b00) begin
        fetch_pc_d = bus.redirect_pc;
        halt_d     = 1'b1;
      end
`endif
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (bus.rsp_valid) begin
        if (drop_q != '0) drop_d = drop_q - 1'b1;
        else              fifo_push = 1'b1;
      end
`ifdef IFU_MISALIGN_CHK_EN
      // Halted fetch keeps the faulting target in fetch_pc for the marker entry.
      if (mis_pend_q) begin
        fifo_push = 1'b1;
        push_ent  = '{pc: fetch_pc_q, inst: '0, misalign: 1'b1};
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      drop_q     <= '0;
      halt_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      halt_q     <= halt_d;
    end
  end

  ifu_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_inst_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .push_i     (fifo_push),
    .push_dat_i (push_ent),
    .pop_i      (fifo_pop),
    .flush_i    (bus.redirect_valid),
    .head_dat_o (head_ent),
    .count_o    (occ)
  );

  // Never flushed: dropped responses still retire their address; occupancy is the inflight count.
  ifu_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
    .clk_i      (clk),
    .rst_ni     (rst),
    .push_i     (req_fire),
    .push_dat_i (fetch_pc_q),
    .pop_i      (bus.rsp_valid),
    .flush_i    (1'b0),
    .head_dat_o (rsp_pc),
    .count_o    (inflight)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: random memory timing, directed stall/redirect/misalign cases.
module tb_ifu_fetch;
  import ifu_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst;

  ifu_fetch_if bus();

  ifu_fetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  entry_t      expq[$];
  logic [63:0] memq[$];
  logic [63:0] mdl_pc;
  bit          mdl_halt;
  int          req_pct, rsp_pct, rdy_pct;
  int          n_req, n_del, snap;
  logic        s_req_vld, s_inst_vld, s_inst_mis;
  logic [63:0] first_pc;
  bit          got_first;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h0BAD_F00D;
  endfunction

  // Entered just after a rising edge; drives one cycle, samples at the falling edge.
  task automatic cycle(input bit redir, input logic [63:0] rpc);
    bit     rsp_now, fire;
    entry_t e;
    bus.req_ready      = ($urandom_range(99) < req_pct);
    rsp_now            = (memq.size() != 0) && ($urandom_range(99) < rsp_pct);
    bus.rsp_valid      = rsp_now;
    bus.rsp_data       = rsp_now ? mem_data(memq[0]) : 32'h0;
    bus.inst_ready     = ($urandom_range(99) < rdy_pct);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    @(negedge clk);
    s_req_vld  = bus.req_valid;
    s_inst_vld = bus.inst_valid;
    s_inst_mis = bus.inst_misalign;
    if (redir || mdl_halt) check("req_vld_blocked", bus.req_valid, 1'b0);
    if (bus.req_valid) check("req_addr", bus.req_addr, mdl_pc);
    fire = bus.req_valid && bus.req_ready;
    if (fire) begin
      memq.push_back(bus.req_addr);
      n_req++;
    end
    if (rsp_now) void'(memq.pop_front());
    if (redir) begin
      expq.delete();
`ifdef IFU_MISALIGN_CHK_EN
      mdl_pc = rpc;
      mdl_halt = (rpc[1:0] != 2'b00);
      if (mdl_halt) expq.push_back('{pc: rpc, inst: 32'h0, misalign: 1'b1});
`else
      mdl_pc = rpc & ~64'h3;
`endif
    end else begin
      if (bus.inst_valid && bus.inst_ready) begin
        n_del++;
        if (!got_first) begin
          first_pc  = bus.inst_pc;
          got_first = 1'b1;
        end
        if (expq.size() == 0) check("inst_vld_noexp", bus.inst_valid, 1'b0);
        else begin
          e = expq.pop_front();
          check("inst_pc", bus.inst_pc, e.pc);
          check("inst", bus.inst, e.inst);
          check("inst_mis", bus.inst_misalign, e.misalign);
        end
      end
      if (fire) begin
        expq.push_back('{pc: mdl_pc, inst: mem_data(mdl_pc), misalign: 1'b0});
        mdl_pc = mdl_pc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 64'h0);
  endtask

  task automatic redirect(input logic [63:0] rpc);
    got_first = 1'b0;
    cycle(1'b1, rpc);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = 32'h0;
    bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 64'h0;
    mdl_pc = RPC; mdl_halt = 1'b0; n_req = 0; n_del = 0; got_first = 1'b0; first_pc = '0;
    req_pct = 100; rsp_pct = 100; rdy_pct = 100;
    repeat (3) @(negedge clk);
    check("rst_req_vld", bus.req_valid, 1'b0);
    check("rst_inst_vld", bus.inst_valid, 1'b0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 64'h0);
    check("rst_inst_mis", bus.inst_misalign, 1'b0);

    // Zero-wait streaming: first request at release, inst two cycles later, then 1/cycle.
    @(posedge clk); #1;
    rst = 1'b1;
    cycle(1'b0, 64'h0);
    check("first_req_vld", s_req_vld, 1'b1);
    check("lat_c0_inst_vld", s_inst_vld, 1'b0);
    cycle(1'b0, 64'h0);
    check("lat_c1_inst_vld", s_inst_vld, 1'b0);
    cycle(1'b0, 64'h0);
    check("lat_c2_inst_vld", s_inst_vld, 1'b1);
    check("first_inst_pc", first_pc, RPC);
    snap = n_del;
    run(20);
    check("throughput", n_del - snap, 20);

    // Core stalled: exactly DEPTH requests, resume one cycle after the first pop.
    rdy_pct = 0;
    redirect(64'h8000_1000);
    snap = n_req;
    run(12);
    check("stall_reqs", n_req - snap, DEPTH);
    check("stall_req_vld", s_req_vld, 1'b0);
    rdy_pct = 100;
    cycle(1'b0, 64'h0);
    check("pop_cycle_req_vld", s_req_vld, 1'b0);
    cycle(1'b0, 64'h0);
    check("resume_req_vld", s_req_vld, 1'b1);
    check("stall_first_pc", first_pc, 64'h8000_1000);
    run(5);

    // Two buffered and two in flight, then redirect: stale responses are dropped.
    rdy_pct = 0;
    redirect(64'h8000_2000);
    snap = n_req;
    run(3);
    rsp_pct = 0;
    run(1);
    check("fill_reqs", n_req - snap, 4);
    check("fill_inst_vld", s_inst_vld, 1'b1);
    redirect(64'h8000_0100);
    rsp_pct = 100; rdy_pct = 100;
    cycle(1'b0, 64'h0);
    check("redir_inst_vld_drop", s_inst_vld, 1'b0);
    check("redir_new_req_vld", s_req_vld, 1'b1);
    run(10);
    check("redir_first_pc", first_pc, 64'h8000_0100);

    // Redirect coinciding with a response and a pop attempt.
    redirect(64'h8000_3000);
    check("same_cyc_inst_vld", s_inst_vld, 1'b1);
    cycle(1'b0, 64'h0);
    check("same_cyc_next_vld", s_inst_vld, 1'b0);
    run(6);
    check("same_cyc_first_pc", first_pc, 64'h8000_3000);

    // 64-bit wrap of the fetch address.
    redirect(64'hFFFF_FFFF_FFFF_FFF8);
    run(10);
    check("wrap_first_pc", first_pc, 64'hFFFF_FFFF_FFFF_FFF8);

`ifdef IFU_MISALIGN_CHK_EN
    redirect(64'h8000_0102);
    cycle(1'b0, 64'h0);
    check("mis_r1_inst_vld", s_inst_vld, 1'b0);
    cycle(1'b0, 64'h0);
    check("mis_r2_inst_vld", s_inst_vld, 1'b1);
    check("mis_r2_flag", s_inst_mis, 1'b1);
    check("mis_pc", first_pc, 64'h8000_0102);
    snap = n_req;
    run(6);
    check("mis_no_reqs", n_req - snap, 0);
    redirect(64'h8000_0200);
    run(8);
    check("mis_resume_pc", first_pc, 64'h8000_0200);
`else
    redirect(64'h8000_0106);
    run(8);
    check("unaligned_forced_pc", first_pc, 64'h8000_0104);
`endif

    // Random memory and core timing with occasional redirects.
    for (int blk = 0; blk < 30; blk++) begin
      req_pct = $urandom_range(100, 30);
      rsp_pct = $urandom_range(100, 30);
      rdy_pct = $urandom_range(100, 30);
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(99) < 3)
          cycle(1'b1, 64'h8000_0000 + 64'($urandom_range(4095)));
        else
          cycle(1'b0, 64'h0);
      end
    end

    // Drain: no new requests; everything outstanding must be delivered.
    req_pct = 0; rsp_pct = 100; rdy_pct = 100;
    run(20);
    check("drain_expq_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
